// File: rtl/plle2_base_model_pkg.sv
// Shared limits and time-rounding helpers for the behavioural base PLL model.
package plle2_base_model_pkg;
  localparam int  MULT_MIN    = 2;
  localparam int  MULT_MAX    = 64;
  localparam int  DIVCLK_MIN  = 1;
  localparam int  DIVCLK_MAX  = 56;
  localparam int  OUTDIV_MIN  = 1;
  localparam int  OUTDIV_MAX  = 128;
  localparam real DUTY_MIN    = 0.01;
  localparam real DUTY_MAX    = 0.99;
  localparam real PHASE_MIN   = 0.0;
  localparam real PHASE_MAX   = 360.0;
  localparam int  LOCK_TOL_PS = 1;
  localparam int  LOCK_COUNT  = 3;

  function automatic int rnd(input real x);
    return $rtoi(x + 0.5);
  endfunction

  function automatic real ps_to_ns(input int ps);
    return real'(ps) / 1000.0;
  endfunction

  function automatic logic within_tol(input int a, input int b);
    return ((a - b) <= LOCK_TOL_PS) && ((b - a) <= LOCK_TOL_PS);
  endfunction
endpackage

// File: rtl/period_count.sv
// Measures the time between the two most recent rising edges of clk, in ps.
module period_count
  import plle2_base_model_pkg::*;
(
  input  logic        RST,
  input  logic        clk,
  output logic [31:0] period_length_1000
);
  timeunit 1ns;
  timeprecision 1ps;

  realtime last_t;
  logic    seen;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      last_t             <= 0.0;
      seen               <= 1'b0;
      period_length_1000 <= '0;
    end else begin
      last_t <= $realtime;
      seen   <= 1'b1;
      if (seen) period_length_1000 <= 32'(rnd(($realtime - last_t) * 1000.0));
    end
  end
endmodule

// File: rtl/plle2_base_model_clkgen.sv
// Free-running clock generator: period tvco*DIVIDE, rounded to 1 ps, with phase and duty.
module plle2_base_model_clkgen
  import plle2_base_model_pkg::*;
#(
  parameter int  DIVIDE = 1,
  parameter real PHASE  = 0.0,
  parameter real DUTY   = 0.5
) (
  input  logic run,
  input  real  tvco,
  output logic clk_o
);
  timeunit 1ns;
  timeprecision 1ps;

  localparam real PH_NORM = PHASE - 360.0 * $floor(PHASE / 360.0);

  int unsigned n_stop;
  int unsigned my_gen;
  logic        clk_q;
  int          per_ps, hi_ps, ph_ps;

  // Every stop bumps n_stop; a loop still sleeping from an older run sees the
  // mismatch on wake-up and abandons its pending edge.
  always_ff @(negedge run) n_stop <= n_stop + 1;

  always begin
    wait (run);
    my_gen = n_stop;
    clk_q  = 1'b0;
    per_ps = rnd(tvco * DIVIDE * 1000.0);
    ph_ps  = rnd(real'(per_ps) * PH_NORM / 360.0);
    if (ph_ps > 0) #(ps_to_ns(ph_ps));
    while (run && my_gen == n_stop) begin
      per_ps = rnd(tvco * DIVIDE * 1000.0);
      if (per_ps < 2) per_ps = 2;
      hi_ps = rnd(DUTY * real'(per_ps));
      if (hi_ps < 1) hi_ps = 1;
      if (hi_ps > per_ps - 1) hi_ps = per_ps - 1;
      clk_q = 1'b1;
      #(ps_to_ns(hi_ps));
      if (!run || my_gen != n_stop) break;
      clk_q = 1'b0;
      #(ps_to_ns(per_ps - hi_ps));
    end
  end

  assign clk_o = clk_q & run & (my_gen == n_stop);
endmodule

// File: rtl/plle2_base_model.sv
// Behavioural 7-series-style base PLL: six divided outputs, feedback clock and lock detect.
module plle2_base_model
  import plle2_base_model_pkg::*;
#(
  parameter real CLKIN1_PERIOD      = 5.0,
  parameter int  CLKFBOUT_MULT      = 5,
  parameter int  DIVCLK_DIVIDE      = 1,
  parameter real CLKFBOUT_PHASE     = 0.0,
  parameter int  CLKOUT0_DIVIDE     = 1,
  parameter int  CLKOUT1_DIVIDE     = 1,
  parameter int  CLKOUT2_DIVIDE     = 1,
  parameter int  CLKOUT3_DIVIDE     = 1,
  parameter int  CLKOUT4_DIVIDE     = 1,
  parameter int  CLKOUT5_DIVIDE     = 1,
  parameter real CLKOUT0_PHASE      = 0.0,
  parameter real CLKOUT1_PHASE      = 0.0,
  parameter real CLKOUT2_PHASE      = 0.0,
  parameter real CLKOUT3_PHASE      = 0.0,
  parameter real CLKOUT4_PHASE      = 0.0,
  parameter real CLKOUT5_PHASE      = 0.0,
  parameter real CLKOUT0_DUTY_CYCLE = 0.5,
  parameter real CLKOUT1_DUTY_CYCLE = 0.5,
  parameter real CLKOUT2_DUTY_CYCLE = 0.5,
  parameter real CLKOUT3_DUTY_CYCLE = 0.5,
  parameter real CLKOUT4_DUTY_CYCLE = 0.5,
  parameter real CLKOUT5_DUTY_CYCLE = 0.5
) (
  input  logic CLKIN1,
  input  logic RST,
  input  logic PWRDWN,
  input  logic CLKFBIN,
  output logic CLKOUT0,
  output logic CLKOUT1,
  output logic CLKOUT2,
  output logic CLKOUT3,
  output logic CLKOUT4,
  output logic CLKOUT5,
  output logic CLKFBOUT,
  output logic LOCKED
);
  timeunit 1ns;
  timeprecision 1ps;

  localparam int  OUT_DIV   [6] = '{CLKOUT0_DIVIDE, CLKOUT1_DIVIDE, CLKOUT2_DIVIDE,
                                    CLKOUT3_DIVIDE, CLKOUT4_DIVIDE, CLKOUT5_DIVIDE};
  localparam real OUT_PHASE [6] = '{CLKOUT0_PHASE, CLKOUT1_PHASE, CLKOUT2_PHASE,
                                    CLKOUT3_PHASE, CLKOUT4_PHASE, CLKOUT5_PHASE};
  localparam real OUT_DUTY  [6] = '{CLKOUT0_DUTY_CYCLE, CLKOUT1_DUTY_CYCLE, CLKOUT2_DUTY_CYCLE,
                                    CLKOUT3_DUTY_CYCLE, CLKOUT4_DUTY_CYCLE, CLKOUT5_DUTY_CYCLE};

  if (CLKFBOUT_MULT < MULT_MIN || CLKFBOUT_MULT > MULT_MAX) begin : g_bad_mult
    $fatal(1, "plle2_base_model: CLKFBOUT_MULT=%0d out of range", CLKFBOUT_MULT);
  end
  if (DIVCLK_DIVIDE < DIVCLK_MIN || DIVCLK_DIVIDE > DIVCLK_MAX) begin : g_bad_divclk
    $fatal(1, "plle2_base_model: DIVCLK_DIVIDE=%0d out of range", DIVCLK_DIVIDE);
  end

  logic        meas_rst_n;
  logic        running;
  logic        run;
  logic [31:0] tin_ps;
  real         tvco;
  int          tvco_ps;
  logic [5:0]  clk_raw;

  // Reset and power-down both clear measurements and silence everything at once.
  assign meas_rst_n = RST & ~PWRDWN;
  assign run        = running & meas_rst_n;

  period_count u_tin (
    .RST               (meas_rst_n),
    .clk               (CLKIN1),
    .period_length_1000(tin_ps)
  );

  assign tvco    = ((tin_ps != '0) ? real'(tin_ps) / 1000.0 : CLKIN1_PERIOD)
                   * DIVCLK_DIVIDE / CLKFBOUT_MULT;
  assign tvco_ps = rnd(tvco * 1000.0);

  always_ff @(posedge CLKIN1 or negedge meas_rst_n) begin
    if (!meas_rst_n) running <= 1'b0;
    else             running <= 1'b1;
  end

  for (genvar n = 0; n < 6; n++) begin : g_out
    if (OUT_DIV[n] < OUTDIV_MIN || OUT_DIV[n] > OUTDIV_MAX) begin : g_bad_div
      $fatal(1, "plle2_base_model: CLKOUT%0d_DIVIDE=%0d out of range", n, OUT_DIV[n]);
    end
    if (OUT_PHASE[n] < PHASE_MIN || OUT_PHASE[n] > PHASE_MAX) begin : g_bad_phase
      $fatal(1, "plle2_base_model: CLKOUT%0d_PHASE out of range", n);
    end
    if (OUT_DUTY[n] < DUTY_MIN || OUT_DUTY[n] > DUTY_MAX) begin : g_bad_duty
      $fatal(1, "plle2_base_model: CLKOUT%0d_DUTY_CYCLE out of range", n);
    end
    plle2_base_model_clkgen #(
      .DIVIDE(OUT_DIV[n]),
      .PHASE (OUT_PHASE[n]),
      .DUTY  (OUT_DUTY[n])
    ) u_gen (
      .run  (run),
      .tvco (tvco),
      .clk_o(clk_raw[n])
    );
  end

  plle2_base_model_clkgen #(
    .DIVIDE(1),
    .PHASE (CLKFBOUT_PHASE),
    .DUTY  (0.5)
  ) u_fb (
    .run  (run),
    .tvco (tvco),
    .clk_o(CLKFBOUT)
  );

  assign {CLKOUT5, CLKOUT4, CLKOUT3, CLKOUT2, CLKOUT1, CLKOUT0} = clk_raw;

  realtime fb_last;
  logic    fb_seen;
  int      good;
  logic    lock_q;

  // Lock needs LOCK_COUNT back-to-back feedback periods within tolerance of Tvco.
  always_ff @(posedge CLKFBIN or negedge meas_rst_n) begin
    if (!meas_rst_n) begin
      fb_last <= 0.0;
      fb_seen <= 1'b0;
      good    <= 0;
      lock_q  <= 1'b0;
    end else begin
      fb_last <= $realtime;
      fb_seen <= 1'b1;
      if (fb_seen) begin
        if (within_tol(rnd(($realtime - fb_last) * 1000.0), tvco_ps)) begin
          if (good < LOCK_COUNT) good <= good + 1;
          if (good >= LOCK_COUNT - 1) lock_q <= 1'b1;
        end else begin
          good   <= 0;
          lock_q <= 1'b0;
        end
      end
    end
  end

  assign LOCKED = lock_q & run;
endmodule

// File: tb/tb_plle2_base_model.sv
// Bench: single looped PLL, three-PLL feedback ring and a non-default PLL, all on one CLKIN1.
module tb_plle2_base_model;
  timeunit 1ns;
  timeprecision 1ps;

  localparam int  NMON = 18;
  localparam real TIN  = 5.0;
  localparam int  MULT = 5;
  localparam int  DIVC = 1;

  logic clkin  = 1'b0;
  logic rst_n  = 1'b0;
  logic pwrdwn = 1'b0;

  logic [5:0]      s_out, c_out;
  logic            s_fb, s_lk, c_fb, c_lk;
  logic [2:0][5:0] r_out;
  logic [2:0]      r_fb, r_lk;

  int checks    = 0;
  int failures  = 0;
  int bad_edges = 0;

  realtime rise_last [NMON];
  realtime rise_prev [NMON];
  realtime fall_last [NMON];
  int      exp_o     [NMON];
  real     exp_duty  [NMON];

  always #2.5 clkin = ~clkin;

  plle2_base_model u_single (
    .CLKIN1(clkin), .RST(rst_n), .PWRDWN(pwrdwn), .CLKFBIN(s_fb),
    .CLKOUT0(s_out[0]), .CLKOUT1(s_out[1]), .CLKOUT2(s_out[2]),
    .CLKOUT3(s_out[3]), .CLKOUT4(s_out[4]), .CLKOUT5(s_out[5]),
    .CLKFBOUT(s_fb), .LOCKED(s_lk)
  );

  for (genvar i = 0; i < 3; i++) begin : g_ring
    plle2_base_model u_ring (
      .CLKIN1(clkin), .RST(rst_n), .PWRDWN(pwrdwn), .CLKFBIN(r_fb[(i + 2) % 3]),
      .CLKOUT0(r_out[i][0]), .CLKOUT1(r_out[i][1]), .CLKOUT2(r_out[i][2]),
      .CLKOUT3(r_out[i][3]), .CLKOUT4(r_out[i][4]), .CLKOUT5(r_out[i][5]),
      .CLKFBOUT(r_fb[i]), .LOCKED(r_lk[i])
    );
  end

  plle2_base_model #(
    .CLKOUT1_DIVIDE(4), .CLKOUT2_DUTY_CYCLE(0.25), .CLKOUT3_PHASE(90.0)
  ) u_cfg (
    .CLKIN1(clkin), .RST(rst_n), .PWRDWN(pwrdwn), .CLKFBIN(c_fb),
    .CLKOUT0(c_out[0]), .CLKOUT1(c_out[1]), .CLKOUT2(c_out[2]),
    .CLKOUT3(c_out[3]), .CLKOUT4(c_out[4]), .CLKOUT5(c_out[5]),
    .CLKFBOUT(c_fb), .LOCKED(c_lk)
  );

  // idx 0-5 single CLKOUTn, 6 single FB, 7-12 last ring CLKOUTn, 13 ring[1] FB, 14-17 cfg CLKOUT0-3
  wire [NMON-1:0] mon     = {c_out[3:0], r_fb[1], r_out[2], s_fb, s_out};
  wire [39:0]     all_out = {s_out, s_fb, s_lk, r_out, r_fb, r_lk, c_out, c_fb, c_lk};

  logic [NMON-1:0] mon_q = '0;
  always @(mon) begin
    for (int i = 0; i < NMON; i++) begin
      if (mon[i] !== mon_q[i]) begin
        if (mon[i]) begin
          rise_prev[i] = rise_last[i];
          rise_last[i] = $realtime;
          if (!rst_n || pwrdwn) bad_edges++;
        end else begin
          fall_last[i] = $realtime;
        end
      end
    end
    mon_q = mon;
  end

  function automatic longint ps(input realtime t);
    return longint'($rtoi(t * 1000.0 + 0.5));
  endfunction

  // Reference: period = Tin*D/M*O in ps, high = duty*period rounded.
  function automatic longint exp_per(input int i);
    return longint'($rtoi(TIN * DIVC / MULT * exp_o[i] * 1000.0 + 0.5));
  endfunction

  function automatic longint exp_high(input int i);
    return longint'($rtoi(exp_duty[i] * real'(exp_per(i)) + 0.5));
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    longint hi, ph, per;
    int     hi_idx [3] = '{6, 14, 16};
    for (int i = 0; i < NMON; i++)
      chk($sformatf("%s_period%0d", tag, i), ps(rise_last[i] - rise_prev[i]), exp_per(i));
    for (int k = 0; k < 3; k++) begin
      int j = hi_idx[k];
      hi = (fall_last[j] > rise_last[j]) ? ps(fall_last[j] - rise_last[j])
                                         : ps(fall_last[j] - rise_prev[j]);
      chk($sformatf("%s_high%0d", tag, j), hi, exp_high(j));
    end
    per = exp_per(14);
    ph  = (((ps(rise_last[17]) - ps(rise_last[14])) % per) + per) % per;
    chk({tag, "_phase90"}, ph, longint'($rtoi(90.0 / 360.0 * real'(per) + 0.5)));
    chk({tag, "_lock_single"}, longint'(s_lk), 1);
    for (int i = 0; i < 3; i++)
      chk($sformatf("%s_lock_ring%0d", tag, i), longint'(r_lk[i]), 1);
    chk({tag, "_lock_cfg"}, longint'(c_lk), 1);
  endtask

  initial begin
    for (int i = 0; i < NMON; i++) begin
      exp_o[i]    = 1;
      exp_duty[i] = 0.5;
    end
    exp_o[15]    = 4;
    exp_duty[16] = 0.25;

    for (int k = 0; k < 3; k++) begin
      #3.3;
      chk($sformatf("rst_hold%0d", k), longint'(all_out), 0);
    end
    #0.1;
    chk("rst_hold_edges", longint'(bad_edges), 0);

    #(real'($urandom_range(1, 4999)) / 1000.0);
    rst_n = 1'b1;
    #(600.0 + real'($urandom_range(0, 999)) / 1000.0);
    check_all("run");

    rst_n = 1'b0;
    #0.001;
    chk("rst_drop", longint'(all_out), 0);
    #(5.0 + real'($urandom_range(0, 15000)) / 1000.0);
    chk("rst_mid_hold", longint'(all_out), 0);
    rst_n = 1'b1;
    #(1000.0 + real'($urandom_range(0, 999)) / 1000.0);
    check_all("relock");

    pwrdwn = 1'b1;
    #0.001;
    chk("pwrdwn_drop", longint'(all_out), 0);
    #(5.0 + real'($urandom_range(0, 15000)) / 1000.0);
    chk("pwrdwn_hold", longint'(all_out), 0);
    pwrdwn = 1'b0;
    #(1000.0 + real'($urandom_range(0, 999)) / 1000.0);
    check_all("pwrup");
    chk("no_edges_when_off", longint'(bad_edges), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
